// File: rtl/reg_req_issuer.sv
// rtl/reg_req_issuer.sv - credit-gated register request issuer with in-order ack tracking
module reg_req_issuer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int ERR_W   = 2,
  parameter int CREDITS = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_wr,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  output logic                         o_req,
  output logic                         o_wr,
  output logic [ADDR_W-1:0]            o_addr,
  output logic [DATA_W-1:0]            o_wr_data,
  input  logic [DATA_W-1:0]            i_rd_data,
  input  logic                         i_ack,
  input  logic                         i_credit,
  input  logic [ERR_W-1:0]             i_err,
  output logic                         rsp_valid,
  output logic                         rsp_wr,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [ERR_W-1:0]             rsp_err,
  input  logic                         i_clr_err,
  output logic                         o_proto_err,
  output logic                         o_timeout,
  output logic [$clog2(CREDITS+1)-1:0] o_outstanding
);

  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam int PTR_W = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CREDITS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_PRE  = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [CNT_W-1:0]   credit_cnt;
  logic [CREDITS-1:0] tag_mem;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               accept;
  logic               ack_ok;
  logic               ack_orphan;
  logic               credit_over;
  logic               pop_tag;
  logic               tmo_clear;
  logic               tmo_hit;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign cmd_ready   = (credit_cnt != '0) && (o_outstanding < CNT_MAX) && !o_timeout;
  assign accept      = cmd_valid && cmd_ready;
  assign ack_ok      = i_ack && (o_outstanding != '0);
  assign ack_orphan  = i_ack && (o_outstanding == '0);
  // A same-cycle accept absorbs the returning credit, so that pair is never an overflow.
  assign credit_over = i_credit && !accept && (credit_cnt == CNT_MAX);
  assign pop_tag     = tag_mem[rd_ptr];
  assign tmo_clear   = (o_outstanding == '0) || i_ack || i_clr_err;
  assign tmo_hit     = !tmo_clear && (tmo_cnt == TMO_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_req     <= 1'b0;
      o_wr      <= 1'b0;
      o_addr    <= '0;
      o_wr_data <= '0;
    end else begin
      o_req <= accept;
      if (accept) begin
        o_wr      <= cmd_wr;
        o_addr    <= cmd_addr;
        o_wr_data <= cmd_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= CNT_MAX;
    end else if (accept && !i_credit) begin
      credit_cnt <= credit_cnt - CNT_ONE;
    end else if (!accept && i_credit && (credit_cnt != CNT_MAX)) begin
      credit_cnt <= credit_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_mem       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_outstanding <= '0;
    end else begin
      if (accept) begin
        tag_mem[wr_ptr] <= cmd_wr;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (ack_ok) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (accept && !ack_ok) begin
        o_outstanding <= o_outstanding + CNT_ONE;
      end else if (!accept && ack_ok) begin
        o_outstanding <= o_outstanding - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
    end else begin
      rsp_valid <= ack_ok;
      if (ack_ok) begin
        rsp_wr    <= pop_tag;
        rsp_rdata <= pop_tag ? '0 : i_rd_data;
        rsp_err   <= i_err;
      end
    end
  end

  // The counter saturates so a stalled ack keeps the timeout asserted without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (tmo_clear) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_timeout   <= 1'b0;
      o_proto_err <= 1'b0;
    end else begin
      if (i_clr_err) begin
        o_timeout <= 1'b0;
      end else if (tmo_hit) begin
        o_timeout <= 1'b1;
      end
      if (i_clr_err) begin
        o_proto_err <= 1'b0;
      end else if (credit_over || ack_orphan) begin
        o_proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_req_issuer.sv
// tb/tb_reg_req_issuer.sv - directed bench with queue-based reference model for reg_req_issuer
module tb_reg_req_issuer;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int ERR_W   = 2;
  localparam int CREDITS = 4;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = $clog2(CREDITS + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              o_req, o_wr;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic [DATA_W-1:0] i_rd_data;
  logic              i_ack, i_credit;
  logic [ERR_W-1:0]  i_err;
  logic              rsp_valid, rsp_wr;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ERR_W-1:0]  rsp_err;
  logic              i_clr_err, o_proto_err, o_timeout;
  logic [CNT_W-1:0]  o_outstanding;

  reg_req_issuer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W), .CREDITS(CREDITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .o_req(o_req), .o_wr(o_wr), .o_addr(o_addr), .o_wr_data(o_wr_data),
    .i_rd_data(i_rd_data), .i_ack(i_ack), .i_credit(i_credit), .i_err(i_err),
    .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .i_clr_err(i_clr_err), .o_proto_err(o_proto_err), .o_timeout(o_timeout),
    .o_outstanding(o_outstanding)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: credits as an integer, outstanding requests as a queue of tags.
  int                m_credits;
  bit                m_q[$];
  int                m_ticks;
  bit                m_proto, m_tmo;
  bit                e_req, e_wr, e_rsp_valid, e_rsp_wr;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_rsp_rdata;
  logic [ERR_W-1:0]  e_rsp_err;

  function automatic bit m_ready();
    return (m_credits > 0) && (m_q.size() < CREDITS) && !m_tmo;
  endfunction

  task automatic m_reset();
    m_credits = CREDITS;
    m_q.delete();
    m_ticks = 0;
    m_proto = 0; m_tmo = 0;
    e_req = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
    e_rsp_valid = 0; e_rsp_wr = 0; e_rsp_rdata = '0; e_rsp_err = '0;
  endtask

  initial begin
    bit acc, ackok, ev, tag;
    int sz;
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        sz    = m_q.size();
        acc   = cmd_valid && m_ready();
        ackok = i_ack && (sz > 0);
        ev    = (i_ack && sz == 0) || (i_credit && !acc && m_credits == CREDITS);
        e_req = acc;
        if (acc) begin
          e_wr = cmd_wr; e_addr = cmd_addr; e_wdata = cmd_wdata;
        end
        e_rsp_valid = ackok;
        if (ackok) begin
          tag         = m_q.pop_front();
          e_rsp_wr    = tag;
          e_rsp_rdata = tag ? '0 : i_rd_data;
          e_rsp_err   = i_err;
        end
        if (acc) m_q.push_back(cmd_wr);
        m_credits = m_credits + (i_credit ? 1 : 0) - (acc ? 1 : 0);
        if (m_credits > CREDITS) m_credits = CREDITS;
        if (sz == 0 || i_ack || i_clr_err) m_ticks = 0;
        else if (m_ticks < TIMEOUT) m_ticks++;
        m_tmo   = i_clr_err ? 1'b0 : (m_tmo || m_ticks == TIMEOUT);
        m_proto = i_clr_err ? 1'b0 : (m_proto || ev);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cmd_ready", cmd_ready, m_ready());
      chk("o_req", o_req, e_req);
      chk("o_wr", o_wr, e_wr);
      chk("o_addr", o_addr, e_addr);
      chk("o_wr_data", o_wr_data, e_wdata);
      chk("rsp_valid", rsp_valid, e_rsp_valid);
      if (e_rsp_valid) begin
        chk("rsp_wr", rsp_wr, e_rsp_wr);
        chk("rsp_rdata", rsp_rdata, e_rsp_rdata);
        chk("rsp_err", rsp_err, e_rsp_err);
      end
      chk("o_proto_err", o_proto_err, m_proto);
      chk("o_timeout", o_timeout, m_tmo);
      chk("o_outstanding", o_outstanding, 64'(m_q.size()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic zero_inputs();
    cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_wdata = '0;
    i_rd_data = '0; i_ack = 0; i_credit = 0; i_err = '0; i_clr_err = 0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_n = 0;
    #1;
    chk("async_rst_outst", o_outstanding, 0);
    chk("async_rst_req", o_req, 0);
    cyc();
    rst_n = 1;
  endtask

  // Streams commands with no credit returns, acking whatever is outstanding each cycle.
  task automatic count_accepts(output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cmd_valid = 1;
      cmd_wr    = 1'(i);
      cmd_addr  = 8'(8'h70 + i);
      i_ack     = (o_outstanding != 0);
      cyc();
      if (o_req) n++;
    end
    cmd_valid = 0;
    i_ack = 0;
  endtask

  initial begin
    int n_acc, first, last, n;
    zero_inputs();
    rst_n = 1;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outst", o_outstanding, 0);
    chk("rst_req", o_req, 0);
    chk("rst_proto", o_proto_err, 0);

    // Six writes, no credits back: only four go out.
    n_acc = 0; first = -1; last = -1;
    cmd_valid = 1; cmd_wr = 1;
    for (int i = 0; i < 10; i++) begin
      cmd_addr  = 8'(8'h10 + n_acc);
      cmd_wdata = 32'(32'h100 + n_acc);
      cyc();
      if (o_req) begin
        chk("t1_addr", o_addr, 64'(8'h10 + n_acc));
        if (first < 0) first = i;
        last = i;
        n_acc++;
        if (n_acc == 6) cmd_valid = 0;
      end
    end
    cmd_valid = 0;
    chk("t1_accepts", n_acc, 4);
    chk("t1_first", first, 0);
    chk("t1_span", last - first, 3);
    chk("t1_ready", cmd_ready, 0);
    do_reset();
    chk("t1_rst_ready", cmd_ready, 1);

    // Single read with ack.
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 8'h20;
    cyc();
    cmd_valid = 0;
    chk("t2_req", o_req, 1);
    chk("t2_addr", o_addr, 8'h20);
    i_ack = 1; i_rd_data = 32'hDEADBEEF; i_err = 0;
    cyc();
    i_ack = 0;
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_wr", rsp_wr, 0);
    chk("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t2_outst", o_outstanding, 0);
    cyc();
    chk("t2_rsp_gone", rsp_valid, 0);

    // Write then read; both acks carry the same read data.
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 8'h30; cmd_wdata = 32'h5555;
    cyc();
    cmd_wr = 0; cmd_addr = 8'h31;
    cyc();
    cmd_valid = 0;
    i_ack = 1; i_rd_data = 32'h1234; i_err = 0;
    cyc();
    chk("t3_rsp1_wr", rsp_wr, 1);
    chk("t3_rsp1_rdata", rsp_rdata, 0);
    i_err = 2'd2;
    cyc();
    i_ack = 0;
    chk("t3_rsp2_valid", rsp_valid, 1);
    chk("t3_rsp2_wr", rsp_wr, 0);
    chk("t3_rsp2_rdata", rsp_rdata, 32'h1234);
    chk("t3_rsp2_err", rsp_err, 2);

    // Credit overflow at reset, then prove the credit count stayed at four.
    do_reset();
    i_credit = 1;
    cyc();
    i_credit = 0;
    chk("t4_proto_credit", o_proto_err, 1);
    i_clr_err = 1;
    cyc();
    i_clr_err = 0;
    chk("t4_proto_clr", o_proto_err, 0);
    count_accepts(n);
    chk("t4_credit_accepts", n, 4);
    chk("t4_outst", o_outstanding, 0);
    chk("t4_ready_nocred", cmd_ready, 0);
    i_ack = 1;
    cyc();
    i_ack = 0;
    chk("t4_proto_orphan", o_proto_err, 1);
    chk("t4_orphan_rsp", rsp_valid, 0);

    // Withheld ack trips the timeout; the late ack still completes.
    do_reset();
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 8'h40;
    cyc();
    cmd_valid = 0;
    n = 0;
    while (n < 20) begin
      cyc();
      n++;
      if (o_timeout) break;
    end
    chk("t5_timeout_cycle", n, 8);
    chk("t5_ready_blocked", cmd_ready, 0);
    i_ack = 1; i_rd_data = 32'hCAFE0001; i_err = 2'd1;
    cyc();
    i_ack = 0;
    chk("t5_late_rsp", rsp_valid, 1);
    chk("t5_late_rdata", rsp_rdata, 32'hCAFE0001);
    chk("t5_still_blocked", cmd_ready, 0);
    i_clr_err = 1;
    cyc();
    i_clr_err = 0;
    chk("t5_ready_after_clr", cmd_ready, 1);
    chk("t5_timeout_clr", o_timeout, 0);

    // Steady state: accept, credit and ack every cycle.
    do_reset();
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 8'h50;
    cyc();
    for (int i = 0; i < 20; i++) begin
      cmd_wr = 1'(i); cmd_addr = 8'(8'h60 + i); cmd_wdata = 32'(i);
      i_credit = 1; i_ack = 1; i_rd_data = 32'(32'h7000 + i);
      cyc();
      chk("t6_outst", o_outstanding, 1);
      chk("t6_req", o_req, 1);
    end
    cmd_valid = 0; i_credit = 0;
    cyc();
    i_ack = 0;
    chk("t6_drained", o_outstanding, 0);
    count_accepts(n);
    chk("t6_credit_accepts", n, 3);
    chk("t6_proto", o_proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_req_issuer.md
Name: reg_req_issuer

Overview:
- Upstream request master that feeds the register file's request/ack/credit port.
- Accepts commands over a valid/ready interface and issues them to the register file, one per cycle, under credit flow control.
- Tracks outstanding requests in order and returns each ack as a response tagged read/write.
- Flags protocol errors and ack timeouts.

Parameters:
- ADDR_W, 8, register address width
- DATA_W, 32, register data width
- ERR_W, 2, error code width from register file
- CREDITS, 4, initial credits = max outstanding requests (power of 2 not required, >=1)
- TIMEOUT, 255, cycles without ack while requests are outstanding before timeout fires (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_wr  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  command address
- cmd_wdata  in  DATA_W  write data
- o_req  out  1  request strobe to register file (one cycle per request)
- o_wr  out  1  request type
- o_addr  out  ADDR_W  request address
- o_wr_data  out  DATA_W  request write data
- i_rd_data  in  DATA_W  read data, valid with i_ack
- i_ack  in  1  completion strobe, in request order
- i_credit  in  1  one-cycle pulse returning one credit
- i_err  in  ERR_W  error code, valid with i_ack
- rsp_valid  out  1  response strobe (no backpressure)
- rsp_wr  out  1  type of completed request
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  ERR_W  error code of completed request
- i_clr_err  in  1  pulse clears sticky flags and timeout counter
- o_proto_err  out  1  sticky protocol violation
- o_timeout  out  1  sticky ack timeout
- o_outstanding  out  clog2(CREDITS+1)  requests issued but not acked

Behaviour:
- Reset values:
  - credit_cnt=CREDITS.
  - All outputs 0; cmd_ready reflects its equation, so it is 1 after reset.
  - Tag FIFO empty, timeout counter 0.
- cmd_ready = (credit_cnt>0) && (o_outstanding<CREDITS) && !o_timeout. It is combinational from state only; it never depends on cmd_valid.
- Issue: on accept, o_req=1 the next cycle with o_wr/o_addr/o_wr_data registered from cmd_*. Back-to-back accepts produce back-to-back o_req. When o_req=0, o_wr/o_addr/o_wr_data hold their last values.
- Accept: credit_cnt decrements, o_outstanding increments, and cmd_wr is pushed into the in-order tag FIFO (depth CREDITS).
- i_credit: credit_cnt increments. Accept and credit in the same cycle leave credit_cnt unchanged.
  - i_credit when credit_cnt==CREDITS (and no same-cycle accept): count saturates and o_proto_err is set.
- i_ack with o_outstanding>0:
  - Pop the tag FIFO; o_outstanding decrements.
  - Next cycle: rsp_valid=1, rsp_wr=popped tag, rsp_err=i_err, rsp_rdata=i_rd_data for reads and 0 for writes (latency 1).
  - Accept and ack in the same cycle leave o_outstanding unchanged; the FIFO push and pop are both honoured.
- i_ack with o_outstanding==0: ignored (no rsp_valid) and o_proto_err is set.
- Timeout counter:
  - Cleared when o_outstanding==0, on any i_ack, or on i_clr_err.
  - Otherwise increments each cycle.
  - On reaching TIMEOUT, o_timeout is set; cmd_ready=0 until i_clr_err. Outstanding state is retained, and late acks still produce responses.
- i_clr_err clears o_proto_err, o_timeout and the timeout counter only. Credits, FIFO and outstanding count are untouched.
- Async reset mid-operation: all state returns to reset values immediately. In-flight responses are discarded.

Test Plan:
- CREDITS=4, no i_credit returns; hold cmd_valid for 6 writes to addr 0x10..0x15 -> exactly 4 accepts, o_req on 4 consecutive cycles with addr 0x10..0x13, then cmd_ready=0.
- Issue read 0x20, ack with i_rd_data=0xDEADBEEF, i_err=0 -> one cycle later rsp_valid=1, rsp_wr=0, rsp_rdata=0xDEADBEEF; o_outstanding returns to 0.
- Issue write then read; ack twice with i_rd_data=0x1234 both times -> rsp_wr=1 with rsp_rdata=0, then rsp_wr=0 with rsp_rdata=0x1234.
- Pulse i_credit at reset, with credit_cnt=4 -> o_proto_err=1 and credit_cnt stays 4. Separately, i_ack with nothing outstanding -> o_proto_err=1 and no rsp_valid.
- TIMEOUT=8: issue one read and withhold i_ack -> o_timeout=1 at cycle 8 and cmd_ready=0. Then i_ack -> response delivered. Then i_clr_err -> cmd_ready=1.
- Same-cycle accept + i_credit + i_ack over 20 cycles of continuous traffic -> credit_cnt constant at 3 and o_outstanding constant at 1.
